capture_dma_sequencer: RTL and testbench

CAPTURE_DMA_SEQUENCER -- requirements
Module: capture_dma_sequencer

---
 rtl/capture_dma_sequencer.sv | 147 ++++++++++++++
 tb/tb_capture_dma_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_dma_sequencer.sv
// Capture-then-DMA sequencer: decimated BRAM capture of DEPTH samples, then one DMA kick.
// Optional DMA-phase watchdog enabled by defining SEQ_DMA_TIMEOUT_EN.
module capture_dma_sequencer #(
  parameter int DEPTH          = 16384,
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              aclk,
  input  logic              rst_ni,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_mode_i,
  input  logic              trig_i,
  input  logic [15:0]       decim_i,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_waddr_o,
  output logic              dma_start_o,
  input  logic              dma_engaged_i,
  input  logic              dma_finished_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [2:0]        state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_KICK    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              arm_q;
  logic [15:0]       dec_q, dec_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              engaged_q, engaged_d;
  logic              arm_edge, wr_now, wr_last, rearm;

`ifdef SEQ_DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign arm_edge = arm_i & ~arm_q;
  assign wr_now   = (state_q == S_CAPTURE) && (dec_q == 16'd0);
  assign wr_last  = wr_now && (addr_q == ADDR_W'(DEPTH - 1));
  assign rearm    = (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR)
                    && (state_d == S_ARMED);

  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      arm_q     <= 1'b0;
      dec_q     <= '0;
      addr_q    <= '0;
      engaged_q <= 1'b0;
`ifdef SEQ_DMA_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_i;
      dec_q     <= dec_d;
      addr_q    <= addr_d;
      engaged_q <= engaged_d;
`ifdef SEQ_DMA_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (arm_edge && !abort_i) state_d = S_ARMED;
      S_DONE, S_ERROR: if (arm_edge) state_d = S_ARMED;
      S_ARMED: begin
        if (abort_i)                       state_d = S_IDLE;
        else if (!trig_mode_i || trig_i)   state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort_i)      state_d = S_IDLE;
        else if (wr_last) state_d = S_KICK;
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        // Completion needs an engaged pulse from this run; a leftover finished is ignored.
        if (engaged_q && dma_finished_i) state_d = S_DONE;
`ifdef SEQ_DMA_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) state_d = S_ERROR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec_d     = dec_q;
    addr_d    = addr_q;
    engaged_d = engaged_q;
`ifdef SEQ_DMA_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    if (rearm) begin
      dec_d  = '0;
      addr_d = '0;
    end
    case (state_q)
      S_CAPTURE: begin
        // >= keeps the counter bounded if decim_i shrinks below the running count
        dec_d = (dec_q >= decim_i) ? 16'd0 : dec_q + 16'd1;
        if (wr_now) addr_d = wr_last ? '0 : addr_q + ADDR_W'(1);
      end
      S_KICK: begin
        engaged_d = 1'b0;
`ifdef SEQ_DMA_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      S_WAIT: begin
        engaged_d = engaged_q | dma_engaged_i;
`ifdef SEQ_DMA_TIMEOUT_EN
        tmo_d     = tmo_q + TMO_W'(1);
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    bram_we_o    = (state_q == S_CAPTURE) && (dec_q == 16'd0);
    bram_waddr_o = addr_q;
    dma_start_o  = (state_q == S_KICK);
    busy_o       = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                   (state_q == S_KICK)  || (state_q == S_WAIT);
    done_o       = (state_q == S_DONE);
`ifdef SEQ_DMA_TIMEOUT_EN
    error_o      = (state_q == S_ERROR);
`else
    error_o      = 1'b0;
`endif
    state_o      = state_q;
  end

endmodule

// File: tb/tb_capture_dma_sequencer.sv
// Randomized directed bench for capture_dma_sequencer; expected write/kick/done timing
// is computed arithmetically from the decimation and trigger rules.
module tb_capture_dma_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 64;

  logic          aclk, rst_ni, arm_i, abort_i, trig_mode_i, trig_i;
  logic [15:0]   decim_i;
  logic          bram_we_o, dma_start_o, dma_engaged_i, dma_finished_i;
  logic [AW-1:0] bram_waddr_o;
  logic          busy_o, done_o, error_o;
  logic [2:0]    state_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int kick_cnt = 0;
  int wr_cyc[$];
  int wr_addr[$];

  capture_dma_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .rst_ni(rst_ni), .arm_i(arm_i), .abort_i(abort_i),
    .trig_mode_i(trig_mode_i), .trig_i(trig_i), .decim_i(decim_i),
    .bram_we_o(bram_we_o), .bram_waddr_o(bram_waddr_o), .dma_start_o(dma_start_o),
    .dma_engaged_i(dma_engaged_i), .dma_finished_i(dma_finished_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .state_o(state_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (bram_we_o === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bram_waddr_o));
    end
    if (dma_start_o === 1'b1) kick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_capture(input int d, input bit tmode, input int tdelay,
                             input int eng_delay, input bit stale, input bit poke);
    int  t0, first, kcyc;
    bit  found, ok;
    @(negedge aclk);
    decim_i = 16'(d); trig_mode_i = tmode; trig_i = 1'b0;
    wr_cyc.delete(); wr_addr.delete();
    arm_i = 1'b1; t0 = cyc;
    @(negedge aclk);
    arm_i = 1'b0;
    check("armed", 32'(state_o), 32'd1);
    first = t0 + 2;
    if (tmode) begin
      ok = 1'b1;
      for (int i = 0; i < tdelay; i++) begin
        @(negedge aclk);
        if (state_o !== 3'd1 || bram_we_o !== 1'b0) ok = 1'b0;
      end
      check("armed_hold", 32'(ok), 32'd1);
      trig_i = 1'b1;
      first = cyc + 1;
    end
    found = 1'b0; kcyc = 0;
    for (int i = 0; i < DEPTH * (d + 1) + 50 && !found; i++) begin
      @(negedge aclk);
      if (poke && i == 5) arm_i = 1'b1;
      if (poke && i == 7) arm_i = 1'b0;
      if (dma_start_o === 1'b1) begin
        found = 1'b1; kcyc = cyc;
        if (!stale) dma_finished_i = 1'b0;
      end
    end
    check("kick_seen", 32'(found), 32'd1);
    check("kick_cyc", kcyc, first + (DEPTH - 1) * (d + 1) + 1);
    check("n_writes", wr_cyc.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < wr_cyc.size(); k++) begin
      check($sformatf("waddr%0d", k), wr_addr[k], k);
      check($sformatf("wcyc%0d", k), wr_cyc[k], first + k * (d + 1));
    end
    @(negedge aclk);
    check("kick_1cyc", 32'(dma_start_o), 32'd0);
    check("dma_wait", 32'(state_o), 32'd4);
    if (stale) begin
      ok = 1'b1; abort_i = 1'b1;
      repeat (8) begin
        @(negedge aclk);
        if (state_o !== 3'd4 || done_o !== 1'b0) ok = 1'b0;
      end
      check("stale_ignored", 32'(ok), 32'd1);
      dma_finished_i = 1'b0;
    end
    repeat (eng_delay) @(negedge aclk);
    dma_engaged_i = 1'b1;
    repeat (5) @(negedge aclk);
    dma_engaged_i = 1'b0; dma_finished_i = 1'b1;
    check("not_done_yet", 32'(done_o), 32'd0);
    @(negedge aclk);
    check("done", 32'({done_o, busy_o, error_o, state_o}), 32'({1'b1, 1'b0, 1'b0, 3'd5}));
    abort_i = 1'b0; trig_i = 1'b0;
  endtask

  initial begin
    int  k0, n0, kcyc, ecyc;
    bit  found;
    rst_ni = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_mode_i = 1'b0; trig_i = 1'b0;
    decim_i = 16'd0; dma_engaged_i = 1'b0; dma_finished_i = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outs", 32'({bram_we_o, dma_start_o, busy_o, done_o, error_o, state_o, bram_waddr_o}), 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge aclk);
    check("idle_after_rst", 32'({busy_o, state_o}), 32'd0);

    run_capture(0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_capture(3, 1'b0, 0, 2, 1'b0, 1'b1);
    run_capture(int'($urandom_range(0, 2)), 1'b1, 100, 1, 1'b0, 1'b0);
    run_capture(int'($urandom_range(0, 3)), 1'b0, 0, int'($urandom_range(0, 4)), 1'b1, 1'b0);

    // Abort on the eighth write
    @(negedge aclk);
    decim_i = 16'($urandom_range(0, 3)); trig_mode_i = 1'b0;
    wr_cyc.delete(); wr_addr.delete(); k0 = kick_cnt;
    arm_i = 1'b1;
    @(negedge aclk);
    arm_i = 1'b0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge aclk);
      if (bram_we_o === 1'b1 && bram_waddr_o === 4'd7) begin found = 1'b1; abort_i = 1'b1; end
    end
    check("abort_point", 32'(found), 32'd1);
    @(negedge aclk);
    check("abort_idle", 32'({state_o, bram_we_o}), 32'd0);
    abort_i = 1'b0;
    repeat (40) @(negedge aclk);
    check("abort_nwr", wr_cyc.size(), 8);
    check("abort_nokick", kick_cnt - k0, 0);
    check("abort_busy", 32'(busy_o), 32'd0);

    // Arm edge together with abort from IDLE
    @(negedge aclk);
    arm_i = 1'b1; abort_i = 1'b1;
    @(negedge aclk);
    check("arm_abort_idle", 32'(state_o), 32'd0);
    arm_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge aclk);
    check("arm_abort_stay", 32'(state_o), 32'd0);

    for (int r = 0; r < 3; r++)
      run_capture(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                  int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);

    // Reset during capture
    @(negedge aclk);
    decim_i = 16'd1; trig_mode_i = 1'b0;
    wr_cyc.delete(); wr_addr.delete(); k0 = kick_cnt;
    arm_i = 1'b1;
    @(negedge aclk);
    arm_i = 1'b0;
    repeat (6) @(negedge aclk);
    rst_ni = 1'b0;
    #1;
    check("rst_async", 32'({state_o, bram_we_o, busy_o}), 32'd0);
    n0 = wr_cyc.size();
    repeat (3) @(negedge aclk);
    rst_ni = 1'b1;
    repeat (60) @(negedge aclk);
    check("rst_nwr", wr_cyc.size(), n0);
    check("rst_nokick", kick_cnt - k0, 0);
    check("rst_idle", 32'(state_o), 32'd0);

`ifdef SEQ_DMA_TIMEOUT_EN
    // DMA never engages: watchdog expiry then re-arm
    @(negedge aclk);
    decim_i = 16'd0; trig_mode_i = 1'b0; dma_finished_i = 1'b0; dma_engaged_i = 1'b0;
    arm_i = 1'b1;
    @(negedge aclk);
    arm_i = 1'b0; found = 1'b0; kcyc = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge aclk);
      if (dma_start_o === 1'b1) begin found = 1'b1; kcyc = cyc; end
    end
    check("tmo_kick", 32'(found), 32'd1);
    found = 1'b0; ecyc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge aclk);
      if (error_o === 1'b1) begin found = 1'b1; ecyc = cyc; end
    end
    check("tmo_error", 32'(found), 32'd1);
    check("tmo_cyc", ecyc, kcyc + 1 + TMO);
    check("tmo_state", 32'({state_o, busy_o}), 32'({3'd6, 1'b0}));
    arm_i = 1'b1;
    @(negedge aclk);
    arm_i = 1'b0;
    check("tmo_rearm", 32'({state_o, error_o}), 32'({3'd1, 1'b0}));
    abort_i = 1'b1;
    @(negedge aclk);
    abort_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
